// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed 7-segment scan controller with double-buffered data
//
// Purpose:
//   Walks NUM_DIGITS digits one at a time through a shared BCD decoder.
//   Each digit is driven for REFRESH_DIV cycles, followed by GAP_CYCLES dark cycles.
//   Display words go into a shadow register through a valid/ready port. They are
//   copied to the active register only while idle or at a frame boundary, so a
//   frame never mixes old and new data.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       scan enable; low forces the display dark
//   wr_valid     new display word offered
//   wr_data      BCD nibbles, [3:0] = digit 0 (rightmost)
//   wr_ready     shadow buffer free
//   bcd_out      nibble to the shared decoder
//   blank        force decoder segments off
//   digit_en     one-hot active-high digit select
//   frame_start  one-cycle pulse when digit 0 begins a frame
//
// Build option:
//   LEADING_ZERO_BLANK_EN - suppress leading zero digits (digit 0 is always shown)

module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      wr_valid,
  input  logic [4*NUM_DIGITS-1:0]   wr_data,
  output logic                      wr_ready,
  output logic [3:0]                bcd_out,
  output logic                      blank,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      frame_start
);

  localparam int IDX_W    = $clog2(NUM_DIGITS);
  localparam int PRE_W    = $clog2(REFRESH_DIV);
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d, idx_next;
  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic                    wr_ready_q, wr_ready_d;
  logic [3:0]              bcd_q, bcd_d;
  logic                    blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_q, frame_d;
  logic                    enter_drive;
  logic [NUM_DIGITS-1:0]   lz_sup;

  assign idx_next = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

  // Scan sequencing, write port and shadow->active transfer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    presc_d     = presc_q;
    gap_d       = gap_q;
    active_d    = active_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    enter_drive = 1'b0;

    if (wr_valid && !pending_q) begin
      shadow_d  = wr_data;
      pending_d = 1'b1;
    end

    if (!enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      presc_d = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d     = S_DRIVE;
          idx_d       = '0;
          presc_d     = '0;
          enter_drive = 1'b1;
        end
        S_DRIVE: begin
          if (presc_q == PRE_W'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end else begin
              // No dead time: move straight to the next digit.
              idx_d       = idx_next;
              enter_drive = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_W'(GAP_LAST)) begin
            gap_d       = '0;
            idx_d       = idx_next;
            state_d     = S_DRIVE;
            enter_drive = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Accept and transfer are exclusive: accept needs pending low, transfer needs it high.
    if (pending_q && (state_q == S_IDLE || (enter_drive && idx_d == '0))) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Digit k>0 is suppressed when it and every digit above it hold zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_sup   = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run  = zero_run && (active_d[4*k +: 4] == 4'd0);
      lz_sup[k] = zero_run;
    end
  end
`else
  assign lz_sup = '0;
`endif

  // Registered outputs follow the state being entered, using the post-transfer data.
  always_comb begin
    bcd_d      = bcd_q;
    blank_d    = 1'b1;
    digit_en_d = '0;
    frame_d    = enter_drive && (idx_d == '0);
    wr_ready_d = !pending_d;
    if (state_d == S_DRIVE) begin
      bcd_d = active_d[{idx_d, 2'b00} +: 4];
      if (!lz_sup[idx_d]) begin
        blank_d    = 1'b0;
        digit_en_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      presc_q    <= '0;
      gap_q      <= '0;
      active_q   <= '0;
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      wr_ready_q <= 1'b1;
      bcd_q      <= 4'd0;
      blank_q    <= 1'b1;
      digit_en_q <= '0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      presc_q    <= presc_d;
      gap_q      <= gap_d;
      active_q   <= active_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      wr_ready_q <= wr_ready_d;
      bcd_q      <= bcd_d;
      blank_q    <= blank_d;
      digit_en_q <= digit_en_d;
      frame_q    <= frame_d;
    end
  end

  assign wr_ready    = wr_ready_q;
  assign bcd_out     = bcd_q;
  assign blank       = blank_q;
  assign digit_en    = digit_en_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl (4 digits, div 4, gap 1)

module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [3:0]  bcd_out;
  logic        blank;
  logic [3:0]  digit_en;
  logic        frame_start;

  seg_scan_ctrl #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .GAP_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .bcd_out    (bcd_out),
    .blank      (blank),
    .digit_en   (digit_en),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] en;
    logic [3:0] bcd;
    logic       fs;
  } slot_t;

  slot_t sb[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected slots for the first n digits of a frame showing d.
  task automatic push_slots(input logic [15:0] d, input int n);
    slot_t s;
    logic  sup;
    for (int k = 0; k < n; k++) begin
      sup = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0) begin
        sup = 1'b1;
        for (int j = k; j < 4; j++) if (d[4*j +: 4] != 4'd0) sup = 1'b0;
      end
`endif
      if (!sup) begin
        s.en  = 4'b0001 << k;
        s.bcd = d[4*k +: 4];
        s.fs  = (k == 0);
        sb.push_back(s);
      end
    end
  endtask

  task automatic wait_fs(input string tag);
    int n = 0;
    while (frame_start !== 1'b1 && n < 100) begin step(); n++; end
    check(tag, frame_start, 1);
  endtask

  task automatic wait_en(input logic [3:0] v, input string tag);
    int n = 0;
    while (digit_en !== v && n < 100) begin step(); n++; end
    check(tag, digit_en, v);
  endtask

  // Monitor: pops an expected slot at each digit turn-on and checks timing.
  logic [3:0] prev_en;
  int cyc, run, dark, last_fs;
  bit had_slot;
  always @(negedge clk) begin
    slot_t e;
    if (!rst_n) begin
      prev_en = '0; run = 0; dark = 0; had_slot = 0; last_fs = -1;
    end else begin
      cyc++;
      if (digit_en != 4'd0) begin
        check("onehot", $countones(digit_en), 1);
        check("lit_blank", blank, 0);
        if (prev_en == 4'd0) begin
          if (sb.size() == 0) check("sb_underflow", digit_en, 0);
          else begin
            e = sb.pop_front();
            check("slot_en", digit_en, e.en);
            check("slot_bcd", bcd_out, e.bcd);
            check("slot_fs", frame_start, e.fs);
          end
`ifndef LEADING_ZERO_BLANK_EN
          if (had_slot && enable) check("gap_len", dark, 1);
`endif
          run = 0;
        end
        run++;
        dark = 0;
      end else begin
        if (prev_en != 4'd0) begin
          if (enable) check("slot_len", run, 4);
          had_slot = 1;
        end
        dark++;
      end
      if (frame_start) begin
        if (last_fs >= 0) check("fs_period", cyc - last_fs, 20);
        last_fs = cyc;
      end
      if (!enable) begin had_slot = 0; last_fs = -1; end
      prev_en = digit_en;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int lit;
    rst_n = 1'b0; enable = 1'b0; wr_valid = 1'b0; wr_data = '0;
    step(); step();
    check("rst_wr_ready", wr_ready, 1);
    check("rst_bcd", bcd_out, 0);
    check("rst_blank", blank, 1);
    check("rst_digit_en", digit_en, 0);
    check("rst_fs", frame_start, 0);
    rst_n = 1'b1;
    step();

    // 1: write while idle, then scan 4321
    wr_valid = 1'b1; wr_data = 16'h4321;
    step();
    wr_valid = 1'b0;
    check("t1_pending", wr_ready, 0);
    step();
    check("t1_idle_xfer", wr_ready, 1);
    push_slots(16'h4321, 4);
    enable = 1'b1;
    wait_fs("t1_first_fs");
    check("t1_d0_bcd", bcd_out, 1);

    // 2: mid-frame write at idx 2 is held until the next frame
    wait_en(4'b0100, "t2_idx2");
    push_slots(16'h9876, 4);
    wr_valid = 1'b1; wr_data = 16'h9876;
    step();
    wr_valid = 1'b0;
    n = 0; lit = 0;
    while (frame_start !== 1'b1 && n < 100) begin
      if (wr_ready) lit++;
      step(); n++;
    end
    check("t2_ready_low", lit, 0);
    check("t2_fs", frame_start, 1);
    check("t2_ready_back", wr_ready, 1);
    check("t2_new_d0", bcd_out, 6);

    // 3: back-to-back writes; the second stalls to the next boundary
    push_slots(16'h1111, 4);
    push_slots(16'h2222, 3);
    wr_valid = 1'b1; wr_data = 16'h1111;
    step();
    wr_data = 16'h2222;
    n = 0;
    while (!wr_ready && n < 100) begin step(); n++; end
    check("t3_stall_cycles", n, 19);
    check("t3_release_fs", frame_start, 1);
    step();
    wr_valid = 1'b0;
    check("t3_second_taken", wr_ready, 0);

    // 4: enable drop at idx 2, then restart
    wait_fs("t4_frame");
    wait_en(4'b0100, "t4_idx2");
    enable = 1'b0;
    step();
    check("t4_dark_en", digit_en, 0);
    check("t4_dark_blank", blank, 1);
    check("t4_no_fs", frame_start, 0);
    check("t4_ready", wr_ready, 1);
    step(); step(); step();
    push_slots(16'h2222, 4);
    enable = 1'b1;
    wait_fs("t4_restart_fs");
    check("t4_restart_d0", digit_en, 4'b0001);

    // 5: async reset in a gap with a write pending
    wr_valid = 1'b1; wr_data = 16'h5555;
    step();
    wr_valid = 1'b0;
    wait_en(4'b1000, "t5_d3");
    wait_en(4'b0000, "t5_gap");
    check("t5_pre_bcd", bcd_out, 2);
    rst_n = 1'b0;
    #2;
    check("t5_async_bcd", bcd_out, 0);
    check("t5_async_ready", wr_ready, 1);
    check("t5_async_blank", blank, 1);
    check("t5_async_en", digit_en, 0);
    step();
    enable = 1'b0;
    rst_n  = 1'b1;
    step();
    push_slots(16'h0000, 4);
    enable = 1'b1;
    wait_fs("t5_fs");
    check("t5_zero_d0", bcd_out, 0);
    repeat (17) step();
    enable = 1'b0;
    step(); step();

`ifdef LEADING_ZERO_BLANK_EN
    // 6: leading zero suppression on 0050
    wr_valid = 1'b1; wr_data = 16'h0050;
    step();
    wr_valid = 1'b0;
    step();
    push_slots(16'h0050, 4);
    enable = 1'b1;
    wait_fs("t6_fs");
    lit = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) step();
      if (!blank) lit++;
    end
    check("t6_lit_cycles", lit, 8);
    enable = 1'b0;
    step(); step();
`endif

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
